// File: rtl/th_pkg.sv
// Shared widths, tag slice positions and bank encoding for the th_branch fetch/branch unit.
package th_pkg;
  localparam int unsigned PC_W    = 10;
  localparam int unsigned TAG_W   = 7;
  localparam int unsigned TAG_MSB = 9;
  localparam int unsigned TAG_LSB = 3;

  typedef logic [PC_W-1:0]  pc_t;
  typedef logic [TAG_W-1:0] tag_t;

  typedef enum logic {
    BANK0 = 1'b0,
    BANK1 = 1'b1
  } bank_e;

  function automatic tag_t pc_tag(input pc_t pc);
    return pc[TAG_MSB:TAG_LSB];
  endfunction
endpackage

// File: rtl/th_branch_if.sv
// Decode/fetch/cache-update signal bundle for th_branch; slave is the branch unit side.
interface th_branch_if;
  import th_pkg::*;

  logic enable_i;
  logic de_lookup_i;
  logic de_nop_i;
  logic de_ack_o;
  logic de_bra_imm_i;
  logic de_bra_reg_i;
  pc_t  de_pc_bra_i;
  logic if_lookup_o;
  logic if_ack_i;
  logic if_packed_i;
  logic if_hit_i;
  pc_t  if_pc_o;
  logic if_pre0_o;
  logic if_pre1_o;
  tag_t if_tag0_o;
  tag_t if_tag1_o;
  logic if_vld0_o;
  logic if_vld1_o;
  logic is_busy_i;
  logic is_update_i;
  tag_t is_newtag_i;
  logic is_lru_ni;
  logic is_bank_i;

  modport slave (
    input  enable_i, de_lookup_i, de_nop_i, de_bra_imm_i, de_bra_reg_i, de_pc_bra_i,
           if_ack_i, if_packed_i, if_hit_i,
           is_busy_i, is_update_i, is_newtag_i, is_lru_ni, is_bank_i,
    output de_ack_o, if_lookup_o, if_pc_o, if_pre0_o, if_pre1_o,
           if_tag0_o, if_tag1_o, if_vld0_o, if_vld1_o
  );

  modport master (
    output enable_i, de_lookup_i, de_nop_i, de_bra_imm_i, de_bra_reg_i, de_pc_bra_i,
           if_ack_i, if_packed_i, if_hit_i,
           is_busy_i, is_update_i, is_newtag_i, is_lru_ni, is_bank_i,
    input  de_ack_o, if_lookup_o, if_pc_o, if_pre0_o, if_pre1_o,
           if_tag0_o, if_tag1_o, if_vld0_o, if_vld1_o
  );
endinterface

// File: rtl/th_tag_bank.sv
// One instruction-cache tag bank: stored tag, valid bit and combinational hit prediction.
module th_tag_bank
  import th_pkg::*;
(
  input  logic clock_i,
  input  logic reset_i,
  input  logic wr,
  input  tag_t newtag,
  input  tag_t pc_tag,
  output tag_t tag,
  output logic vld,
  output logic pre
);
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      tag <= '0;
      vld <= 1'b0;
    end else if (wr) begin
      tag <= newtag;
      vld <= 1'b1;
    end
  end

  assign pre = vld & (tag == pc_tag);
endmodule

// File: rtl/th_branch.sv
// Fetch PC sequencer with decode branches and a 2-bank tag predictor with 1-bit LRU.
// Optional macro TH_BRANCH_PACKED_EN: advance by 2 on packed fetch words.
module th_branch
  import th_pkg::*;
(
  input logic        clock_i,
  input logic        reset_i,
  th_branch_if.slave bus
);
  pc_t   pc;
  pc_t   pc_nxt;
  pc_t   inc;
  logic  run;
  bank_e lru;
  bank_e wr_bank;
  bank_e hit_bank;
  logic  de_ack;
  logic  lookup;
  logic  fetch_hit;
  logic  bra_take;
  logic  update;
  logic  pre0, pre1;
  logic  vld0, vld1;
  tag_t  tag0, tag1;

  assign lookup    = run & bus.enable_i & ~bus.is_busy_i;
  assign fetch_hit = lookup & bus.if_ack_i & bus.if_hit_i;
  assign bra_take  = (bus.de_bra_imm_i | bus.de_bra_reg_i) & ~bus.de_nop_i & bus.enable_i;
  assign update    = bus.is_update_i & bus.enable_i;
  assign wr_bank   = bus.is_lru_ni ? bank_e'(bus.is_bank_i) : lru;
  // Bank 0 wins when both banks predict a hit.
  assign hit_bank  = (~pre0 & pre1) ? BANK1 : BANK0;

`ifdef TH_BRANCH_PACKED_EN
  assign inc = bus.if_packed_i ? pc_t'(2) : pc_t'(1);
`else
  logic unused_packed;
  assign unused_packed = bus.if_packed_i;
  assign inc = pc_t'(1);
`endif

  always_comb begin
    pc_nxt = pc;
    if (bra_take) begin
      pc_nxt = bus.de_bra_reg_i ? bus.de_pc_bra_i : pc + bus.de_pc_bra_i;
    end else if (fetch_hit) begin
      pc_nxt = pc + inc;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      pc     <= '0;
      run    <= 1'b0;
      lru    <= BANK0;
      de_ack <= 1'b0;
    end else if (bus.enable_i) begin
      run    <= 1'b1;
      pc     <= pc_nxt;
      de_ack <= bra_take | bus.de_lookup_i;
      if (update) begin
        lru <= bank_e'(~wr_bank);
      end else if (fetch_hit) begin
        lru <= bank_e'(~hit_bank);
      end
    end
  end

  th_tag_bank u_bank0 (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .wr      (update & (wr_bank == BANK0)),
    .newtag  (bus.is_newtag_i),
    .pc_tag  (pc_tag(pc)),
    .tag     (tag0),
    .vld     (vld0),
    .pre     (pre0)
  );

  th_tag_bank u_bank1 (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .wr      (update & (wr_bank == BANK1)),
    .newtag  (bus.is_newtag_i),
    .pc_tag  (pc_tag(pc)),
    .tag     (tag1),
    .vld     (vld1),
    .pre     (pre1)
  );

  assign bus.de_ack_o    = de_ack;
  assign bus.if_lookup_o = lookup;
  assign bus.if_pc_o     = pc;
  assign bus.if_pre0_o   = pre0;
  assign bus.if_pre1_o   = pre1;
  assign bus.if_tag0_o   = tag0;
  assign bus.if_tag1_o   = tag1;
  assign bus.if_vld0_o   = vld0;
  assign bus.if_vld1_o   = vld1;
endmodule

// File: tb/tb_th_branch.sv
// Directed self-checking bench for th_branch (honours TH_BRANCH_PACKED_EN when defined).
module tb_th_branch;
  logic clk;
  logic rst;
  int unsigned total;
  int unsigned bad;

  th_branch_if bus ();

  th_branch dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pc(input logic [9:0] v);
    bus.de_bra_reg_i = 1'b1;
    bus.de_pc_bra_i  = v;
    tick();
    bus.de_bra_reg_i = 1'b0;
    bus.de_pc_bra_i  = '0;
    check("load_pc", 32'(bus.if_pc_o), 32'(v));
  endtask

  task automatic tag_write(input logic [6:0] t, input logic lru_n, input logic bank);
    bus.is_update_i = 1'b1;
    bus.is_newtag_i = t;
    bus.is_lru_ni   = lru_n;
    bus.is_bank_i   = bank;
    tick();
    bus.is_update_i = 1'b0;
    bus.is_lru_ni   = 1'b0;
    bus.is_bank_i   = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.enable_i     = 1'b1;
    bus.de_lookup_i  = 1'b0;
    bus.de_nop_i     = 1'b0;
    bus.de_bra_imm_i = 1'b0;
    bus.de_bra_reg_i = 1'b0;
    bus.de_pc_bra_i  = '0;
    bus.if_ack_i     = 1'b0;
    bus.if_packed_i  = 1'b0;
    bus.if_hit_i     = 1'b0;
    bus.is_busy_i    = 1'b0;
    bus.is_update_i  = 1'b0;
    bus.is_newtag_i  = '0;
    bus.is_lru_ni    = 1'b0;
    bus.is_bank_i    = 1'b0;

    tick();
    check("rst_pc", 32'(bus.if_pc_o), 32'd0);
    check("rst_lookup", 32'(bus.if_lookup_o), 32'd0);
    check("rst_ack", 32'(bus.de_ack_o), 32'd0);
    check("rst_pre", {30'd0, bus.if_pre1_o, bus.if_pre0_o}, 32'd0);
    check("rst_vld", {30'd0, bus.if_vld1_o, bus.if_vld0_o}, 32'd0);

    // Sequential fetch; ack during the first (non-running) cycle is ignored.
    rst = 1'b0;
    bus.if_ack_i = 1'b1;
    bus.if_hit_i = 1'b1;
    tick();
    check("run_lookup", 32'(bus.if_lookup_o), 32'd1);
    check("seq_pc0", 32'(bus.if_pc_o), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("seq_pc", 32'(bus.if_pc_o), 32'(i));
    end
    bus.if_ack_i = 1'b0;
    bus.if_hit_i = 1'b0;

    // Miss holds PC.
    load_pc(10'd5);
    check("bra_reg_ack", 32'(bus.de_ack_o), 32'd1);
    bus.if_ack_i = 1'b1;
    tick();
    check("miss_hold1", 32'(bus.if_pc_o), 32'd5);
    check("ack_pulse_end", 32'(bus.de_ack_o), 32'd0);
    tick();
    check("miss_hold2", 32'(bus.if_pc_o), 32'd5);
    bus.if_hit_i = 1'b1;
    tick();
    check("miss_then_hit", 32'(bus.if_pc_o), 32'd6);
    bus.if_ack_i = 1'b0;
    bus.if_hit_i = 1'b0;

    // Packed advance and wrap.
    load_pc(10'd4);
    bus.if_ack_i = 1'b1;
    bus.if_hit_i = 1'b1;
    bus.if_packed_i = 1'b1;
    tick();
`ifdef TH_BRANCH_PACKED_EN
    check("packed_adv", 32'(bus.if_pc_o), 32'd6);
`else
    check("packed_adv", 32'(bus.if_pc_o), 32'd5);
`endif
    bus.if_ack_i = 1'b0;
    bus.if_packed_i = 1'b0;
    load_pc(10'd1023);
    bus.if_ack_i = 1'b1;
    tick();
    check("wrap_1023", 32'(bus.if_pc_o), 32'd0);
    bus.if_ack_i = 1'b0;
    load_pc(10'd1022);
    bus.if_ack_i = 1'b1;
    bus.if_packed_i = 1'b1;
    tick();
`ifdef TH_BRANCH_PACKED_EN
    check("wrap_1022p", 32'(bus.if_pc_o), 32'd0);
`else
    check("wrap_1022p", 32'(bus.if_pc_o), 32'd1023);
`endif
    bus.if_ack_i = 1'b0;
    bus.if_hit_i = 1'b0;
    bus.if_packed_i = 1'b0;

    // Branches.
    load_pc(10'd10);
    bus.de_bra_imm_i = 1'b1;
    bus.de_pc_bra_i  = 10'd20;
    tick();
    check("bra_imm_pc", 32'(bus.if_pc_o), 32'd30);
    check("bra_imm_ack", 32'(bus.de_ack_o), 32'd1);
    bus.de_nop_i = 1'b1;
    tick();
    check("nop_pc", 32'(bus.if_pc_o), 32'd30);
    check("nop_ack", 32'(bus.de_ack_o), 32'd0);
    bus.de_nop_i     = 1'b0;
    bus.de_bra_reg_i = 1'b1;
    bus.de_pc_bra_i  = 10'd100;
    tick();
    check("reg_prio", 32'(bus.if_pc_o), 32'd100);
    bus.de_bra_reg_i = 1'b0;
    bus.de_pc_bra_i  = 10'd3;
    bus.if_ack_i = 1'b1;
    bus.if_hit_i = 1'b1;
    tick();
    check("bra_over_adv", 32'(bus.if_pc_o), 32'd103);
    bus.de_bra_imm_i = 1'b0;
    bus.de_pc_bra_i  = '0;
    bus.if_ack_i = 1'b0;
    bus.if_hit_i = 1'b0;
    bus.de_lookup_i = 1'b1;
    tick();
    check("probe_ack", 32'(bus.de_ack_o), 32'd1);
    bus.de_lookup_i = 1'b0;
    tick();
    check("probe_ack_end", 32'(bus.de_ack_o), 32'd0);

    // Tag banks and LRU.
    tag_write(7'h05, 1'b1, 1'b1);
    load_pc(10'h028);
    check("vld1", 32'(bus.if_vld1_o), 32'd1);
    check("vld0", 32'(bus.if_vld0_o), 32'd0);
    check("tag1", 32'(bus.if_tag1_o), 32'h05);
    check("pre1", 32'(bus.if_pre1_o), 32'd1);
    check("pre0", 32'(bus.if_pre0_o), 32'd0);
    bus.is_busy_i = 1'b1;
    #1;
    check("busy_lookup", 32'(bus.if_lookup_o), 32'd0);
    bus.is_busy_i = 1'b0;
    tag_write(7'h09, 1'b0, 1'b0);
    check("lru_wr_b0", 32'(bus.if_tag0_o), 32'h09);
    tag_write(7'h0a, 1'b0, 1'b0);
    check("lru_wr_b1", 32'(bus.if_tag1_o), 32'h0a);
    load_pc(10'h048);
    check("pre0_hit", 32'(bus.if_pre0_o), 32'd1);
    bus.if_ack_i = 1'b1;
    bus.if_hit_i = 1'b1;
    tick();
    bus.if_ack_i = 1'b0;
    bus.if_hit_i = 1'b0;
    tag_write(7'h0b, 1'b0, 1'b0);
    check("lru_after_hit_t1", 32'(bus.if_tag1_o), 32'h0b);
    check("lru_after_hit_t0", 32'(bus.if_tag0_o), 32'h09);

    // Enable low freezes state.
    load_pc(10'd7);
    tick();
    bus.enable_i = 1'b0;
    bus.if_ack_i = 1'b1;
    bus.if_hit_i = 1'b1;
    bus.de_bra_reg_i = 1'b1;
    bus.de_pc_bra_i  = 10'd50;
    bus.is_update_i  = 1'b1;
    bus.is_newtag_i  = 7'h33;
    #1;
    check("dis_lookup", 32'(bus.if_lookup_o), 32'd0);
    tick();
    check("dis_pc", 32'(bus.if_pc_o), 32'd7);
    check("dis_ack", 32'(bus.de_ack_o), 32'd0);
    check("dis_tag1", 32'(bus.if_tag1_o), 32'h0b);
    bus.enable_i = 1'b1;
    bus.if_ack_i = 1'b0;
    bus.if_hit_i = 1'b0;
    bus.de_bra_reg_i = 1'b0;
    bus.de_pc_bra_i  = '0;
    bus.is_update_i  = 1'b0;

    // Asynchronous reset mid-operation.
    bus.de_lookup_i = 1'b1;
    tick();
    check("pre_rst_ack", 32'(bus.de_ack_o), 32'd1);
    bus.de_lookup_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_pc", 32'(bus.if_pc_o), 32'd0);
    check("arst_ack", 32'(bus.de_ack_o), 32'd0);
    check("arst_vld", {30'd0, bus.if_vld1_o, bus.if_vld0_o}, 32'd0);
    check("arst_lookup", 32'(bus.if_lookup_o), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/th_branch.md
TH_BRANCH -- requirements
Module: th_branch

Interface
REQ-001 SHALL have ports, one per line: name  direction  width  meaning.
- clock_i  in  1  single clock, all state on rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- enable_i  in  1  global advance enable; low freezes all state except reset.
- de_lookup_i  in  1  decode probe request; acknowledged via de_ack_o.
- de_nop_i  in  1  decode slot is a NOP; suppresses de_bra_*.
- de_ack_o  out  1  decode acknowledge (branch taken or probe done).
- de_bra_imm_i  in  1  PC-relative branch request.
- de_bra_reg_i  in  1  absolute (register) branch request.
- de_pc_bra_i  in  10  branch offset (imm) or target (reg).
- if_lookup_o  out  1  fetch lookup request for if_pc_o.
- if_ack_i  in  1  fetch accepted the lookup.
- if_packed_i  in  1  fetched word holds two packed instructions.
- if_hit_i  in  1  accepted lookup hit in the instruction cache.
- if_pc_o  out  10  current fetch PC.
- if_pre0_o, if_pre1_o  out  1  bank 0/1 predicted hit for if_pc_o.
- if_tag0_o, if_tag1_o  out  7  bank 0/1 stored tag.
- if_vld0_o, if_vld1_o  out  1  bank 0/1 tag valid.
- is_busy_i  in  1  cache refill in progress; blocks lookups.
- is_update_i  in  1  tag write strobe.
- is_newtag_i  in  7  tag to write.
- is_lru_ni  in  1  active-low: write internal LRU bank instead of is_bank_i.
- is_bank_i  in  1  explicit target bank for tag write.
REQ-002 SHALL have no parameters; PC width 10, tag width 7 (tag = PC[9:3]).

Function
REQ-003 SHALL assert if_lookup_o = run & enable_i & ~is_busy_i, run being a flag set on the first edge after reset release.
REQ-004 SHALL advance PC on an edge with if_ack_i & if_hit_i & enable_i: +2 if if_packed_i, else +1, modulo 1024 (wrap 1023->0, 1022+2->0).
REQ-005 SHALL hold PC when if_ack_i & ~if_hit_i (miss); lookup reissued next cycle with same PC.
REQ-006 SHALL, when (de_bra_imm_i | de_bra_reg_i) & ~de_nop_i & enable_i, load PC at the next edge with if_pc_o + de_pc_bra_i (imm, mod 1024) or de_pc_bra_i (reg); branch overrides any same-cycle advance.
REQ-007 SHALL give de_bra_reg_i priority when both branch inputs are high.
REQ-008 SHALL pulse de_ack_o for one cycle, the cycle after an accepted branch or a de_lookup_i sample (enable_i high).
REQ-009 SHALL drive if_preN_o = if_vldN_o & (if_tagN_o == if_pc_o[9:3]) combinationally.
REQ-010 SHALL, on is_update_i & enable_i, write is_newtag_i into bank (is_lru_ni ? is_bank_i : lru) and set its valid bit; other bank unchanged.
REQ-011 SHALL keep 1-bit lru register: on if_ack_i & if_hit_i, lru <= ~(bank with if_preN_o, bank 0 if both); on update, lru <= ~written bank.
REQ-012 SHALL ignore if_ack_i/if_hit_i while if_lookup_o is low.

Reset
REQ-013 SHALL, while reset_i high, force PC=0, run=0, lru=0, tags=0, valids=0, de_ack_o=0; hence if_lookup_o=0, if_preN_o=0.
REQ-014 SHALL clear state asynchronously on reset mid-operation, discarding pending branch/ack.

Configuration
REQ-015 SHALL support macro TH_BRANCH_PACKED_EN: defined -> REQ-004 +2 on if_packed_i; undefined -> if_packed_i ignored, always +1.

Structure
REQ-016 SHALL place PC width, tag width, tag slice positions in shared package th_pkg.
REQ-017 SHALL implement per-bank tag/valid storage as one sub-module th_tag_bank, instantiated twice.

Verification
REQ-018 Reset pulse, then ack=hit=1 three cycles, packed=0 -> if_pc_o 0,1,2,3; if_lookup_o low during reset, high first cycle after.
REQ-019 PC=5, ack=1, hit=0 two cycles, then hit=1 -> PC holds 5 twice, then 6.
REQ-020 PC=4, hit=1, packed=1 (macro defined) -> 6; macro undefined -> 5; PC=1023, hit=1 -> 0.
REQ-021 PC=10, bra_imm=1, dest=20 -> PC=30 next edge, de_ack_o one pulse; with de_nop_i=1 -> no branch, no ack.
REQ-022 update tag 0x05 bank 1 (lru_n=1), PC=0x028 -> vld1=1, tag1=5, pre1=1, pre0=0; is_busy_i=1 -> if_lookup_o=0.
